gates_sweep: RTL and testbench
==============================

GATES_SWEEP -- requirements
Module: gates_sweep

Interface
REQ-001 SHALL have parameter SIZE, default 1: width of each src output; every bit of a src carries the same stimulus value.
REQ-002 SHALL have parameter SETTLE, default 1, legal 1..15: wait cycles between driving a vector and sampling dut_out.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE or DONE.
REQ-006 src1..src4  output  SIZE each  stimulus to the gate-test unit under check.
REQ-007 dut_out  input  22  observed outputs: [0] not, [1] not2, [2] buf, [3] buf2; [4..9] 1-input and/or/xor/nand/nor/xnor; [10..15] same, 3-input; [16..21] same, 4-input.
REQ-008 busy  output  1  high from sweep start until final check.
REQ-009 done  output  1  high in DONE state.
REQ-010 pass  output  1  done and err_count==0.
REQ-011 err_count  output  8  count of vectors with at least one mismatching bit, saturating at 255.
REQ-012 first_fail_vec  output  4; first_fail_mask  output  22 (see Configuration).

Function
REQ-013 SHALL use FSM states IDLE, WAIT, CHECK, DONE.
REQ-014 IDLE/DONE with start=1: load vector 0 onto srcs, clear err_count and wait counter, go to WAIT.
REQ-015 Vector v (0..15) SHALL drive src1={SIZE{v[0]}}, src2={SIZE{v[1]}}, src3={SIZE{v[2]}}, src4={SIZE{v[3]}}.
REQ-016 WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-017 CHECK SHALL compare dut_out to the golden model for the current vector; any mismatch increments err_count (saturating).
REQ-018 CHECK with v<15 SHALL load v+1 and return to WAIT; with v==15 SHALL go to DONE and leave srcs unchanged.
REQ-019 Golden model: not/not2 = ~s1; buf/buf2 = s1; 1-input and/or/xor = s1, nand/nor/xnor = ~s1; N-input gates are reductions over s1..sN, inverted for nand/nor/xnor.
REQ-020 Latency: done SHALL rise exactly 16*(SETTLE+1) cycles after the edge sampling start.
REQ-021 start while busy SHALL be ignored; start held high SHALL restart a sweep on each entry to DONE after one DONE cycle.
REQ-022 done/pass SHALL hold in DONE until start or reset.

Reset
REQ-023 reset SHALL force IDLE; srcs=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_mask=0, including mid-sweep; reset dominates start.

Configuration
REQ-024 With GATES_SWEEP_FIRST_FAIL_EN defined, first_fail_vec/first_fail_mask SHALL capture the vector index and XOR mismatch mask of the first failing CHECK of a sweep and hold until next start or reset.
REQ-025 Without GATES_SWEEP_FIRST_FAIL_EN, both ports SHALL exist and be tied to 0, with no capture registers.

Structure
REQ-026 Package gates_sweep_pkg SHALL hold the FSM state typedef, NUM_OUTS=22, NUM_VECS=16, and the dut_out bit-index constants.
REQ-027 Golden model SHALL be sub-module gates_sweep_model (4-bit vector in, 22-bit expected out, combinational).

Verification
REQ-028 Correct reference DUT, SETTLE=1, start pulse -> done at cycle 32 after start, pass=1, err_count=0, first_fail_mask=0.
REQ-029 dut_out[6] stuck 0 -> err_count=8, pass=0, first_fail_vec=1, first_fail_mask=22'h000040.
REQ-030 dut_out[0] inverted always -> err_count=16, first_fail_vec=0, first_fail_mask=22'h000001.
REQ-031 Reset asserted during vector 5 -> next cycle srcs=0, busy=0, err_count=0; fresh start then yields pass=1.
REQ-032 SETTLE=3, SIZE=4, correct DUT -> done at cycle 64, pass=1; srcs observed as 4'hF/4'h0 only.
REQ-033 start held high throughout -> start ignored while busy, one DONE cycle between sweeps, err_count cleared at each restart.

Source files
------------

// File: rtl/gates_sweep_pkg.sv
// Shared types and constants for the gate-test sweeper: FSM states, sizes and dut_out bit map.
// Optional first-failure capture is enabled by defining GATES_SWEEP_FIRST_FAIL_EN.
package gates_sweep_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam int NUM_OUTS = 22;
  localparam int NUM_VECS = 16;

  localparam int IDX_NOT  = 0;
  localparam int IDX_NOT2 = 1;
  localparam int IDX_BUF  = 2;
  localparam int IDX_BUF2 = 3;

  // Base index of each six-gate group, and gate offsets within a group
  localparam int IDX_G1 = 4;
  localparam int IDX_G3 = 10;
  localparam int IDX_G4 = 16;

  localparam int OFS_AND  = 0;
  localparam int OFS_OR   = 1;
  localparam int OFS_XOR  = 2;
  localparam int OFS_NAND = 3;
  localparam int OFS_NOR  = 4;
  localparam int OFS_XNOR = 5;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gates_sweep_if.sv
// Stimulus/observation bus between the sweeper (master) and its environment (slave).
interface gates_sweep_if #(
  parameter int SIZE = 1
);
  import gates_sweep_pkg::*;

  logic                start;
  logic [SIZE-1:0]     src1;
  logic [SIZE-1:0]     src2;
  logic [SIZE-1:0]     src3;
  logic [SIZE-1:0]     src4;
  logic [NUM_OUTS-1:0] dut_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [7:0]          err_count;
  logic [3:0]          first_fail_vec;
  logic [NUM_OUTS-1:0] first_fail_mask;

  modport master (
    input  start, dut_out,
    output src1, src2, src3, src4, busy, done, pass, err_count,
           first_fail_vec, first_fail_mask
  );

  modport slave (
    output start, dut_out,
    input  src1, src2, src3, src4, busy, done, pass, err_count,
           first_fail_vec, first_fail_mask
  );

endinterface

// File: rtl/gates_sweep_model.sv
// Combinational golden model: expected gate-unit outputs for a 4-bit stimulus vector.
module gates_sweep_model
  import gates_sweep_pkg::*;
(
  input  logic [3:0]          vec,
  output logic [NUM_OUTS-1:0] expected
);

  // Packs one gate group in OFS_AND..OFS_XNOR order from its and/or/xor reductions
  function automatic logic [5:0] gate_group(input logic a, input logic o, input logic x);
    return {~x, ~o, ~a, x, o, a};
  endfunction

  always_comb begin
    expected                = '0;
    expected[IDX_NOT]       = ~vec[0];
    expected[IDX_NOT2]      = ~vec[0];
    expected[IDX_BUF]       = vec[0];
    expected[IDX_BUF2]      = vec[0];
    expected[IDX_G1 +: 6]   = gate_group(vec[0], vec[0], vec[0]);
    expected[IDX_G3 +: 6]   = gate_group(&vec[2:0], |vec[2:0], ^vec[2:0]);
    expected[IDX_G4 +: 6]   = gate_group(&vec[3:0], |vec[3:0], ^vec[3:0]);
  end

endmodule

// File: rtl/gates_sweep.sv
// Sweeps all 16 input vectors through an external gate-test unit and counts mismatching vectors.
// Define GATES_SWEEP_FIRST_FAIL_EN to capture the index and mask of the first failing vector.
module gates_sweep
  import gates_sweep_pkg::*;
#(
  parameter int SIZE   = 1,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           reset,
  gates_sweep_if.master bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_VEC    = 4'(NUM_VECS - 1);

  state_t              state;
  logic [3:0]          vec;
  logic [3:0]          wait_cnt;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [7:0]          err_count_q;
  logic [NUM_OUTS-1:0] expected;
  logic [NUM_OUTS-1:0] diff;
  logic                mismatch;
  logic                start_ok;

  gates_sweep_model u_model (
    .vec      (vec),
    .expected (expected)
  );

  assign diff     = bus.dut_out ^ expected;
  assign mismatch = |diff;
  assign start_ok = bus.start && (state == IDLE || state == DONE);

  // The vector register directly drives the stimulus, so srcs hold their last value in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vec         <= '0;
      wait_cnt    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= WAIT;
            vec         <= '0;
            wait_cnt    <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt == SETTLE_LAST) state <= CHECK;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        CHECK: begin
          if (mismatch) err_count_q <= sat_inc(err_count_q);
          wait_cnt <= '0;
          if (vec == LAST_VEC) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_count_q == 8'd0) && !mismatch;
          end else begin
            vec   <= vec + 4'd1;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.src1      = {SIZE{vec[0]}};
  assign bus.src2      = {SIZE{vec[1]}};
  assign bus.src3      = {SIZE{vec[2]}};
  assign bus.src4      = {SIZE{vec[3]}};
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;

`ifdef GATES_SWEEP_FIRST_FAIL_EN
  logic [3:0]          ff_vec;
  logic [NUM_OUTS-1:0] ff_mask;

  // A zero error count means no vector of this sweep has failed yet
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_vec  <= '0;
      ff_mask <= '0;
    end else if (start_ok) begin
      ff_vec  <= '0;
      ff_mask <= '0;
    end else if (state == CHECK && mismatch && err_count_q == 8'd0) begin
      ff_vec  <= vec;
      ff_mask <= diff;
    end
  end

  assign bus.first_fail_vec  = ff_vec;
  assign bus.first_fail_mask = ff_mask;
`else
  assign bus.first_fail_vec  = '0;
  assign bus.first_fail_mask = '0;
`endif

endmodule

// File: tb/tb_gates_sweep.sv
// Table-driven bench for gates_sweep: fault-injected gate units, reset, restart and SETTLE/SIZE variants.
module tb_gates_sweep;
  import gates_sweep_pkg::*;

`ifdef GATES_SWEEP_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   fault_mode;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gates_sweep_if #(.SIZE(1)) bus1 ();
  gates_sweep_if #(.SIZE(4)) bus3 ();

  gates_sweep #(.SIZE(1), .SETTLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  gates_sweep #(.SIZE(4), .SETTLE(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  // Behavioural gate-test unit written gate by gate
  function automatic logic [NUM_OUTS-1:0] gate_unit(input logic s1, input logic s2,
                                                    input logic s3, input logic s4);
    logic [NUM_OUTS-1:0] r;
    r[0]  = ~s1;                   r[1]  = ~s1;
    r[2]  = s1;                    r[3]  = s1;
    r[4]  = s1;                    r[5]  = s1;
    r[6]  = s1;                    r[7]  = ~s1;
    r[8]  = ~s1;                   r[9]  = ~s1;
    r[10] = s1 & s2 & s3;          r[11] = s1 | s2 | s3;
    r[12] = s1 ^ s2 ^ s3;          r[13] = ~(s1 & s2 & s3);
    r[14] = ~(s1 | s2 | s3);       r[15] = ~(s1 ^ s2 ^ s3);
    r[16] = s1 & s2 & s3 & s4;     r[17] = s1 | s2 | s3 | s4;
    r[18] = s1 ^ s2 ^ s3 ^ s4;     r[19] = ~(s1 & s2 & s3 & s4);
    r[20] = ~(s1 | s2 | s3 | s4);  r[21] = ~(s1 ^ s2 ^ s3 ^ s4);
    return r;
  endfunction

  function automatic logic [NUM_OUTS-1:0] apply_fault(input logic [NUM_OUTS-1:0] r, input int mode);
    logic [NUM_OUTS-1:0] f;
    f = r;
    case (mode)
      1: f[6]  = 1'b0;
      2: f[0]  = ~r[0];
      3: f[21] = 1'b1;
      4: f[12] = 1'b0;
      5: f[14] = 1'b0;
      6: f[16] = 1'b1;
      7: f     = ~r;
      8: begin f[6] = 1'b0; f[7] = 1'b0; end
      default: f = r;
    endcase
    return f;
  endfunction

  assign bus1.dut_out = apply_fault(gate_unit(bus1.src1[0], bus1.src2[0], bus1.src3[0], bus1.src4[0]),
                                    fault_mode);
  assign bus3.dut_out = gate_unit(bus3.src1[0], bus3.src2[0], bus3.src3[0], bus3.src4[0]);

  typedef struct {
    int                  mode;
    logic [7:0]          err;
    logic                pass;
    logic [3:0]          ffv;
    logic [NUM_OUTS-1:0] ffm;
  } vec_t;

  vec_t vectors[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic start_pulse(input int mode);
    @(negedge clk);
    fault_mode  = mode;
    bus1.start  = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    checkOutput("busy_after_start", {31'd0, bus1.busy}, 32'd1);
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if ((which == 1) ? bus1.done : bus3.done) break;
    end
  endtask

  task automatic applyStimulus(input int mode, output int latency);
    start_pulse(mode);
    wait_done(1, latency);
  endtask

  initial begin
    int lat;
    int n;
    int bad_src;
    logic [3:0] s1v;

    vectors[0] = '{0, 8'd0,  1'b1, 4'd0, 22'h000000};
    vectors[1] = '{1, 8'd8,  1'b0, 4'd1, 22'h000040};
    vectors[2] = '{2, 8'd16, 1'b0, 4'd0, 22'h000001};
    vectors[3] = '{3, 8'd8,  1'b0, 4'd1, 22'h200000};
    vectors[4] = '{4, 8'd8,  1'b0, 4'd1, 22'h001000};
    vectors[5] = '{5, 8'd2,  1'b0, 4'd0, 22'h004000};
    vectors[6] = '{6, 8'd15, 1'b0, 4'd0, 22'h010000};
    vectors[7] = '{7, 8'd16, 1'b0, 4'd0, 22'h3FFFFF};
    vectors[8] = '{8, 8'd16, 1'b0, 4'd0, 22'h000080};

    fault_mode = 0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);

    // Reset must win over a simultaneous start
    @(negedge clk);
    bus1.start = 1'b1;
    bus3.start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_busy",  {31'd0, bus1.busy}, 32'd0);
    checkOutput("rst_done",  {31'd0, bus1.done}, 32'd0);
    checkOutput("rst_pass",  {31'd0, bus1.pass}, 32'd0);
    checkOutput("rst_err",   {24'd0, bus1.err_count}, 32'd0);
    checkOutput("rst_srcs",  {28'd0, bus1.src4, bus1.src3, bus1.src2, bus1.src1}, 32'd0);
    checkOutput("rst_ffv",   {28'd0, bus1.first_fail_vec}, 32'd0);
    checkOutput("rst_ffm",   {10'd0, bus1.first_fail_mask}, 32'd0);
    checkOutput("rst_busy3", {31'd0, bus3.busy}, 32'd0);
    @(negedge clk);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", {31'd0, bus1.busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vectors[i].mode, lat);
      checkOutput($sformatf("latency_m%0d", vectors[i].mode), lat, 32'd32);
      checkOutput($sformatf("err_m%0d", vectors[i].mode), {24'd0, bus1.err_count}, {24'd0, vectors[i].err});
      checkOutput($sformatf("pass_m%0d", vectors[i].mode), {31'd0, bus1.pass}, {31'd0, vectors[i].pass});
      checkOutput($sformatf("busy_m%0d", vectors[i].mode), {31'd0, bus1.busy}, 32'd0);
      checkOutput($sformatf("ffv_m%0d", vectors[i].mode), {28'd0, bus1.first_fail_vec},
                  FF_EN ? {28'd0, vectors[i].ffv} : 32'd0);
      checkOutput($sformatf("ffm_m%0d", vectors[i].mode), {10'd0, bus1.first_fail_mask},
                  FF_EN ? {10'd0, vectors[i].ffm} : 32'd0);
      checkOutput($sformatf("srcs_done_m%0d", vectors[i].mode),
                  {28'd0, bus1.src4, bus1.src3, bus1.src2, bus1.src1}, 32'hF);
      repeat (3) @(posedge clk);
      #1;
      checkOutput($sformatf("done_hold_m%0d", vectors[i].mode), {31'd0, bus1.done}, 32'd1);
    end

    // Reset in the middle of vector 5 with a faulty unit, then a clean sweep
    start_pulse(1);
    n = 0;
    s1v = {bus1.src4, bus1.src3, bus1.src2, bus1.src1};
    while (n < 100 && s1v != 4'd5) begin
      @(posedge clk);
      #1;
      n++;
      s1v = {bus1.src4, bus1.src3, bus1.src2, bus1.src1};
    end
    checkOutput("mid_vec5", {28'd0, s1v}, 32'd5);
    checkOutput("mid_err", {24'd0, bus1.err_count}, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_srcs", {28'd0, bus1.src4, bus1.src3, bus1.src2, bus1.src1}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, bus1.busy}, 32'd0);
    checkOutput("mid_rst_err",  {24'd0, bus1.err_count}, 32'd0);
    checkOutput("mid_rst_ffm",  {10'd0, bus1.first_fail_mask}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, lat);
    checkOutput("post_rst_latency", lat, 32'd32);
    checkOutput("post_rst_pass", {31'd0, bus1.pass}, 32'd1);

    // Start held high: ignored while busy, one DONE cycle, then an automatic restart
    @(negedge clk);
    fault_mode = 2;
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1, lat);
    checkOutput("hold_latency1", lat, 32'd32);
    checkOutput("hold_err1", {24'd0, bus1.err_count}, 32'd16);
    @(posedge clk);
    #1;
    checkOutput("hold_restart_done", {31'd0, bus1.done}, 32'd0);
    checkOutput("hold_restart_busy", {31'd0, bus1.busy}, 32'd1);
    checkOutput("hold_restart_err",  {24'd0, bus1.err_count}, 32'd0);
    wait_done(1, lat);
    checkOutput("hold_latency2", lat, 32'd32);
    checkOutput("hold_err2", {24'd0, bus1.err_count}, 32'd16);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_done_stays", {31'd0, bus1.done}, 32'd1);
    checkOutput("hold_pass", {31'd0, bus1.pass}, 32'd0);

    // Wider stimulus and longer settle on the second instance
    @(negedge clk);
    bus3.start = 1'b1;
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    bad_src = 0;
    lat = 0;
    while (lat < 300) begin
      if (!(bus3.src1 inside {4'h0, 4'hF}) || !(bus3.src2 inside {4'h0, 4'hF}) ||
          !(bus3.src3 inside {4'h0, 4'hF}) || !(bus3.src4 inside {4'h0, 4'hF}))
        bad_src++;
      @(posedge clk);
      lat++;
      #1;
      if (bus3.done) break;
    end
    checkOutput("s3_latency", lat, 32'd64);
    checkOutput("s3_pass", {31'd0, bus3.pass}, 32'd1);
    checkOutput("s3_err", {24'd0, bus3.err_count}, 32'd0);
    checkOutput("s3_bad_src", bad_src, 32'd0);
    checkOutput("s3_srcs_done", {16'd0, bus3.src4, bus3.src3, bus3.src2, bus3.src1}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
